// File: rtl/trap_ctrl.sv
// Machine-mode trap entry/return sequencer: detects exceptions and interrupts at execute,
// stalls the pipe, writes mepc/mcause, redirects the PC, and owns mstatus.MIE/MPIE.
module trap_ctrl #(
  parameter bit VECTORED_EN = 1'b1,
  parameter bit RESET_MIE   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instrValid,
  input  logic [31:0] pcCur,
  input  logic        excInstrMisaligned,
  input  logic        excIllegal,
  input  logic        excEbreak,
  input  logic        excEcall,
  input  logic        mret,
  input  logic        irqTimer,
  input  logic        irqExt,
  input  logic        mstatusWe,
  input  logic [31:0] mstatusDi,
  output logic [31:0] mstatusDo,
  input  logic [31:0] mtvecDi,
  input  logic [31:0] mepcDi,
  output logic        mepcWe,
  output logic [31:0] mepcDo,
  output logic        mcauseWe,
  output logic [31:0] mcauseDo,
  output logic        stall,
  output logic        pcRedirectValid,
  output logic [31:0] pcRedirect
);

  typedef enum logic [1:0] {StIdle, StSave, StJump} state_e;

  state_e      state_q, state_d;
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic        irq_q, irq_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] pc_q, pc_d;
  logic        ret_q, ret_d;

  logic        exc_any, irq_any, take, ret_go;
  logic        cause_irq;
  logic [4:0]  cause_code;
  logic [31:0] tvec_base;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      mie_q   <= RESET_MIE;
      mpie_q  <= 1'b0;
      irq_q   <= 1'b0;
      code_q  <= 5'd0;
      pc_q    <= 32'd0;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mie_q   <= mie_d;
      mpie_q  <= mpie_d;
      irq_q   <= irq_d;
      code_q  <= code_d;
      pc_q    <= pc_d;
      ret_q   <= ret_d;
    end
  end

  // Take/mret decode; reset is folded in so nothing leaks out while reset is held.
  always_comb begin
    exc_any = excInstrMisaligned | excIllegal | excEbreak | excEcall;
    irq_any = mie_q & (irqTimer | irqExt);
    take    = (state_q == StIdle) & instrValid & (exc_any | irq_any) & ~reset;
    ret_go  = (state_q == StIdle) & instrValid & mret & ~take & ~reset;

    cause_irq  = 1'b0;
    cause_code = 5'd11;
    if (mie_q & irqExt) begin
      cause_irq  = 1'b1;
      cause_code = 5'd11;
    end else if (mie_q & irqTimer) begin
      cause_irq  = 1'b1;
      cause_code = 5'd7;
    end else if (excInstrMisaligned) begin
      cause_code = 5'd0;
    end else if (excIllegal) begin
      cause_code = 5'd2;
    end else if (excEbreak) begin
      cause_code = 5'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    mie_d   = mie_q;
    mpie_d  = mpie_q;
    irq_d   = irq_q;
    code_d  = code_q;
    pc_d    = pc_q;
    ret_d   = ret_q;

    unique case (state_q)
      StIdle: begin
        if (take) begin
          irq_d   = cause_irq;
          code_d  = cause_code;
          pc_d    = pcCur;
          mpie_d  = mie_q;
          mie_d   = 1'b0;
          ret_d   = 1'b0;
          state_d = StSave;
        end else if (ret_go) begin
          mie_d   = mpie_q;
          mpie_d  = 1'b1;
          ret_d   = 1'b1;
          state_d = StJump;
        end else if (mstatusWe) begin
          mie_d  = mstatusDi[3];
          mpie_d = mstatusDi[7];
        end
      end
      StSave:  state_d = StJump;
      StJump:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tvec_base       = {mtvecDi[31:2], 2'b00};
    stall           = take | ret_go | (state_q != StIdle);
    mepcWe          = (state_q == StSave);
    mcauseWe        = (state_q == StSave);
    mepcDo          = mepcWe ? pc_q : 32'd0;
    mcauseDo        = mcauseWe ? {irq_q, 26'd0, code_q} : 32'd0;
    pcRedirectValid = (state_q == StJump);
    pcRedirect      = 32'd0;
    if (pcRedirectValid) begin
      if (ret_q) begin
        pcRedirect = {mepcDi[31:2], 2'b00};
      end else if (VECTORED_EN && (mtvecDi[1:0] == 2'b01) && irq_q) begin
        pcRedirect = tvec_base + {25'd0, code_q, 2'b00};
      end else begin
        pcRedirect = tvec_base;
      end
    end
    mstatusDo = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
  end

  // Only MIE/MPIE of the mstatus write data and the aligned part of mepc matter here.
  logic unused_bits;
  assign unused_bits = ^{mstatusDi[31:8], mstatusDi[6:4], mstatusDi[2:0], mepcDi[1:0]};

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: trap entry, vectoring, priority, mret, CSR write conflicts
// and asynchronous reset mid-sequence.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instrValid;
  logic [31:0] pcCur;
  logic        excInstrMisaligned, excIllegal, excEbreak, excEcall;
  logic        mret, irqTimer, irqExt;
  logic        mstatusWe;
  logic [31:0] mstatusDi, mstatusDo;
  logic [31:0] mtvecDi, mepcDi;
  logic        mepcWe, mcauseWe;
  logic [31:0] mepcDo, mcauseDo;
  logic        stall, pcRedirectValid;
  logic [31:0] pcRedirect;

  int n_checks = 0;
  int n_fail   = 0;

  trap_ctrl #(
    .VECTORED_EN(1'b1),
    .RESET_MIE  (1'b0)
  ) u_dut (
    .clk               (clk),
    .reset             (reset),
    .instrValid        (instrValid),
    .pcCur             (pcCur),
    .excInstrMisaligned(excInstrMisaligned),
    .excIllegal        (excIllegal),
    .excEbreak         (excEbreak),
    .excEcall          (excEcall),
    .mret              (mret),
    .irqTimer          (irqTimer),
    .irqExt            (irqExt),
    .mstatusWe         (mstatusWe),
    .mstatusDi         (mstatusDi),
    .mstatusDo         (mstatusDo),
    .mtvecDi           (mtvecDi),
    .mepcDi            (mepcDi),
    .mepcWe            (mepcWe),
    .mepcDo            (mepcDo),
    .mcauseWe          (mcauseWe),
    .mcauseDo          (mcauseDo),
    .stall             (stall),
    .pcRedirectValid   (pcRedirectValid),
    .pcRedirect        (pcRedirect)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    instrValid = 0; excInstrMisaligned = 0; excIllegal = 0; excEbreak = 0; excEcall = 0;
    mret = 0; irqTimer = 0; irqExt = 0; mstatusWe = 0;
  endtask

  task automatic write_mstatus(input logic [31:0] val);
    mstatusWe = 1; mstatusDi = val;
    next_cycle();
    mstatusWe = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1; pcCur = 0; mstatusDi = 0; mtvecDi = 0; mepcDi = 0;
    next_cycle();
    next_cycle();
    check_eq("rst_mstatus", mstatusDo, 32'h0000_1800);
    check_eq("rst_stall", stall, 0);
    check_eq("rst_mepcwe", mepcWe, 0);
    check_eq("rst_redir", pcRedirectValid, 0);
    reset = 0;
    next_cycle();
    check_eq("idle_stall", stall, 0);

    // Illegal instruction
    instrValid = 1; excIllegal = 1; pcCur = 32'h104; mtvecDi = 32'h200;
    #1 check_eq("ill_take_stall", stall, 1);
    check_eq("ill_take_mepcwe", mepcWe, 0);
    next_cycle();
    clear_inputs();
    #1 check_eq("ill_save_stall", stall, 1);
    check_eq("ill_save_mepcwe", mepcWe, 1);
    check_eq("ill_save_mcausewe", mcauseWe, 1);
    check_eq("ill_save_mepc", mepcDo, 32'h104);
    check_eq("ill_save_mcause", mcauseDo, 32'h2);
    check_eq("ill_save_redir", pcRedirectValid, 0);
    next_cycle();
    check_eq("ill_jump_stall", stall, 1);
    check_eq("ill_jump_redirv", pcRedirectValid, 1);
    check_eq("ill_jump_redir", pcRedirect, 32'h200);
    check_eq("ill_jump_mepcwe", mepcWe, 0);
    next_cycle();
    check_eq("ill_done_stall", stall, 0);
    check_eq("ill_done_redirv", pcRedirectValid, 0);
    check_eq("ill_mstatus", mstatusDo, 32'h1800);

    // Vectored timer interrupt; irq drops right after take
    write_mstatus(32'h88);
    check_eq("tmr_mstatus_pre", mstatusDo, 32'h1888);
    instrValid = 1; irqTimer = 1; pcCur = 32'h40; mtvecDi = 32'h201;
    #1 check_eq("tmr_take_stall", stall, 1);
    next_cycle();
    clear_inputs();
    #1 check_eq("tmr_mcause", mcauseDo, 32'h8000_0007);
    check_eq("tmr_mepc", mepcDo, 32'h40);
    check_eq("tmr_mstatus_post", mstatusDo, 32'h1880);
    next_cycle();
    check_eq("tmr_redir", pcRedirect, 32'h21C);
    check_eq("tmr_redirv", pcRedirectValid, 1);
    next_cycle();

    // Priority: ext irq over ecall with MIE=1, vectored to base+44
    write_mstatus(32'h8);
    instrValid = 1; irqExt = 1; excEcall = 1; pcCur = 32'h80; mtvecDi = 32'h201;
    next_cycle();
    clear_inputs();
    #1 check_eq("pri_irq_mcause", mcauseDo, 32'h8000_000B);
    next_cycle();
    check_eq("pri_irq_redir", pcRedirect, 32'h22C);
    next_cycle();
    // MIE is now 0: ecall wins, exceptions are never vectored
    instrValid = 1; irqExt = 1; excEcall = 1;
    next_cycle();
    clear_inputs();
    #1 check_eq("pri_exc_mcause", mcauseDo, 32'hB);
    next_cycle();
    check_eq("pri_exc_redir", pcRedirect, 32'h200);
    next_cycle();

    // mret
    write_mstatus(32'h80);
    check_eq("mret_mstatus_pre", mstatusDo, 32'h1880);
    mepcDi = 32'h104; instrValid = 1; mret = 1;
    #1 check_eq("mret_stall", stall, 1);
    check_eq("mret_n_mepcwe", mepcWe, 0);
    next_cycle();
    clear_inputs();
    #1 check_eq("mret_redirv", pcRedirectValid, 1);
    check_eq("mret_redir", pcRedirect, 32'h104);
    check_eq("mret_n1_mepcwe", mepcWe, 0);
    check_eq("mret_mstatus", mstatusDo, 32'h1888);
    next_cycle();
    check_eq("mret_done_stall", stall, 0);

    // mstatus write loses to a trap take, and is ignored in SAVE
    write_mstatus(32'h0);
    check_eq("cfl_mstatus_pre", mstatusDo, 32'h1800);
    instrValid = 1; excEbreak = 1; mstatusWe = 1; mstatusDi = 32'h8; mtvecDi = 32'h200;
    next_cycle();
    clear_inputs();
    mstatusWe = 1; mstatusDi = 32'h88;
    #1 check_eq("cfl_mcause", mcauseDo, 32'h3);
    check_eq("cfl_mstatus", mstatusDo, 32'h1800);
    next_cycle();
    mstatusWe = 0;
    check_eq("cfl_save_ign", mstatusDo, 32'h1800);
    next_cycle();

    // Asynchronous reset while in SAVE
    write_mstatus(32'h8);
    instrValid = 1; excIllegal = 1; pcCur = 32'h300;
    next_cycle();
    clear_inputs();
    #1 check_eq("rst_save_mepcwe", mepcWe, 1);
    check_eq("rst_save_mstatus", mstatusDo, 32'h1880);
    reset = 1;
    #1 check_eq("rst_async_mepcwe", mepcWe, 0);
    check_eq("rst_async_mcausewe", mcauseWe, 0);
    check_eq("rst_async_stall", stall, 0);
    check_eq("rst_async_mstatus", mstatusDo, 32'h1800);
    next_cycle();
    check_eq("rst_no_redir0", pcRedirectValid, 0);
    reset = 0;
    next_cycle();
    check_eq("rst_no_redir1", pcRedirectValid, 0);
    check_eq("rst_idle_stall", stall, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
